// File: rtl/dw_arb_binctl.sv
// Binary-priority arbiter with one registered grant, a hold timeout and a lock override.
// Optional round-robin policy: define DW_ARB_BINCTL_RR_EN (default build is fixed highest-index priority).
module dw_arb_binctl #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    state_t             state_r, state_n;
    logic [N_REQ-1:0]   grant_r, grant_n;
    logic [IDX_W-1:0]   grant_idx_r, grant_idx_n;
    logic               busy_r, busy_n;
    logic               timeout_r, timeout_n;
    logic [7:0]         hold_r, hold_n;

    logic               owner_req_s, owner_lock_s, force_s, any_s, arb_go_s;
    logic [N_REQ-1:0]   elig_s;
    logic [IDX_W-1:0]   win_idx_s;
    int                 start_s;

    // Highest eligible index at or below start, wrapping downward past 0 to N_REQ-1.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] v, input int start);
        logic [IDX_W-1:0] w;
        int               j;
        w = '1;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (start - k + N_REQ) % N_REQ;
            if (v[j]) begin
                w = IDX_W'(j);
            end
        end
        return w;
    endfunction

`ifdef DW_ARB_BINCTL_RR_EN
    logic [IDX_W-1:0] ptr_r, ptr_n;

    // Search start tracks one below the last winner.
    always_comb begin
        start_s = int'(ptr_r);
        ptr_n   = ptr_r;
        if (arb_go_s) begin
            ptr_n = (win_idx_s == '0) ? IDX_W'(N_REQ - 1) : win_idx_s - IDX_W'(1);
        end else begin
            ptr_n = ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= IDX_W'(N_REQ - 1);
        end else begin
            ptr_r <= ptr_n;
        end
    end
`else
    assign start_s = N_REQ - 1;
`endif

    // Owner status and the request set that competes this cycle (owner masked on a forced release).
    always_comb begin
        owner_req_s  = |(req & grant_r);
        owner_lock_s = |(lock & grant_r);
        force_s      = (state_r == OWN) && owner_req_s && (hold_r == HOLD_MAX) && !owner_lock_s;
        if (force_s) begin
            elig_s = req & ~grant_r;
        end else begin
            elig_s = req;
        end
        any_s     = |elig_s;
        win_idx_s = pick(elig_s, start_s);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        grant_idx_n = grant_idx_r;
        busy_n      = busy_r;
        timeout_n   = 1'b0;
        hold_n      = hold_r;
        arb_go_s    = 1'b0;
        case (state_r)
            IDLE: begin
                arb_go_s = enable && any_s;
            end
            OWN: begin
                if (!owner_req_s || force_s) begin
                    timeout_n   = force_s;
                    arb_go_s    = enable && any_s;
                    state_n     = IDLE;
                    grant_n     = '0;
                    grant_idx_n = '1;
                    busy_n      = 1'b0;
                    hold_n      = 8'd0;
                end else if (hold_r != HOLD_MAX) begin
                    hold_n = hold_r + 8'd1;
                end else begin
                    hold_n = hold_r;
                end
            end
            default: begin
                state_n     = IDLE;
                grant_n     = '0;
                grant_idx_n = '1;
                busy_n      = 1'b0;
                hold_n      = 8'd0;
            end
        endcase
        if (arb_go_s) begin
            state_n     = OWN;
            grant_n     = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
            grant_idx_n = win_idx_s;
            busy_n      = 1'b1;
            hold_n      = 8'd0;
        end else begin
            hold_n = hold_n;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            grant_idx_r <= '1;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            hold_r      <= 8'd0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            grant_idx_r <= grant_idx_n;
            busy_r      <= busy_n;
            timeout_r   <= timeout_n;
            hold_r      <= hold_n;
        end
    end

    assign grant     = grant_r;
    assign grant_idx = grant_idx_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_dw_arb_binctl.sv
// Randomized bench for dw_arb_binctl (N_REQ=8, MAX_HOLD=4) against an owner/hold-count reference model.
module tb_dw_arb_binctl;

    localparam int N  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         busy;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    int m_owner = -1;
    int m_hold  = 0;
    int m_tmo   = 0;
    int m_ptr   = N - 1;

    dw_arb_binctl #(.N_REQ(N), .IDX_W(3), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .lock(lock),
        .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Choose a winner from the candidate set m; returns -1 if m is empty.
    function automatic int choose(input logic [N-1:0] m);
        int w;
        w = -1;
`ifdef DW_ARB_BINCTL_RR_EN
        for (int k = 0; k < N; k++) begin
            if (w < 0 && m[(m_ptr - k + N) % N]) w = (m_ptr - k + N) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (m[i]) w = i;
        end
`endif
        return w;
    endfunction

    task automatic model_grant(input logic [N-1:0] m);
        int w;
        w = enable ? choose(m) : -1;
        m_owner = w;
        m_hold  = 0;
`ifdef DW_ARB_BINCTL_RR_EN
        if (w >= 0) m_ptr = (w == 0) ? N - 1 : w - 1;
`endif
    endtask

    task automatic model_edge();
        logic [N-1:0] m;
        if (!rst_n) begin
            m_owner = -1; m_hold = 0; m_tmo = 0; m_ptr = N - 1;
        end else begin
            m_tmo = 0;
            if (m_owner < 0) begin
                model_grant(req);
            end else if (!req[m_owner]) begin
                model_grant(req);
            end else if (m_hold == MH - 1 && !lock[m_owner]) begin
                m_tmo = 1;
                m = req;
                m[m_owner] = 1'b0;
                model_grant(m);
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic step_check();
        logic [N-1:0] eg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check_val("grant", 32'(grant), 32'(eg));
        check_val("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd7 : 32'(m_owner));
        check_val("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check_val("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_check();
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0; run(2);
        rst_n = 1'b1; enable = 1'b1;
        req = 8'h00; run(5);
        req = 8'h12; run(1);
        check_val("first_grant", 32'(grant), 32'h10);
        req = 8'h02; run(1);
        check_val("handoff_idx", 32'(grant_idx), 32'd1);
        req = 8'h00; run(2);
        req = 8'h80; run(10);
        req = 8'h81; lock = 8'h80; run(8);
        lock = 8'h00; run(1);
        check_val("lock_release", 32'(grant), 32'h01);
        check_val("lock_release_tmo", 32'(timeout), 32'd1);
        run(3);
        req = 8'h00; run(2);
        req = 8'h08; run(1);
        enable = 1'b0; run(2);
        rst_n = 1'b0; run(1);
        check_val("rst_drop", 32'(grant), 32'h00);
        rst_n = 1'b1; run(3);
        enable = 1'b1; req = 8'hFF; run(1);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 11) == 0) lock = 8'($urandom) & 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 249) != 0);
            step_check();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dw_arb_binctl.md
DW_ARB_BINCTL -- requirements
Module: dw_arb_binctl

Interface
REQ-001 SHALL provide parameter N_REQ, default 8: number of requesters, range 2..32.
REQ-002 SHALL provide parameter IDX_W, default 3: grant index width, ceil(log2(N_REQ)) or wider.
REQ-003 SHALL provide parameter MAX_HOLD, default 16: maximum cycles one grant may be held when unlocked, range 2..255.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 enable  input  1  1 = new grants may be issued; 0 = no new grants.
REQ-007 req  input  N_REQ  request vector, bit i = requester i.
REQ-008 lock  input  N_REQ  lock[i]=1 exempts an active grant to i from the hold timeout.
REQ-009 grant  output  N_REQ  one-hot registered grant, or all zeros.
REQ-010 grant_idx  output  IDX_W  binary index of the granted requester; all ones when no grant.
REQ-011 busy  output  1  1 while any grant is active.
REQ-012 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and OWN (one grant active).
REQ-014 In IDLE with enable=1 and req!=0, SHALL select a winner and assert grant, grant_idx and busy on the next rising edge, giving one-cycle latency; the state SHALL become OWN.
REQ-015 In IDLE with enable=0 or req=0, outputs SHALL hold their idle values: grant=0, grant_idx=all ones, busy=0.
REQ-016 Winner selection SHALL be by binary priority encoding of the eligible request vector, with the highest index winning.
REQ-017 In OWN, grant SHALL remain stable while req[owner]=1 and the hold count is below MAX_HOLD-1, or while lock[owner]=1.
REQ-018 In OWN, when req[owner]=0 is sampled, the grant SHALL be released: if enable=1 and other requests are present, the next grant SHALL appear on the same edge with no idle cycle; otherwise the state SHALL become IDLE.
REQ-019 The hold counter SHALL clear on every new grant and increment for each OWN cycle, saturating at MAX_HOLD-1.
REQ-020 When the hold counter equals MAX_HOLD-1, req[owner]=1 and lock[owner]=0, the block SHALL force a release and pulse timeout=1 for exactly one cycle.
REQ-021 On a forced release, the owner SHALL be masked from that arbitration; if no other eligible request exists, the state SHALL become IDLE for at least one cycle.
REQ-022 Deasserting lock[owner] after the hold counter has saturated SHALL force a release on the next edge.
REQ-023 enable=0 SHALL NOT revoke an active grant; it SHALL only block new grants.
REQ-024 Requests that rise and fall entirely inside another owner's tenure SHALL be lost; the block SHALL NOT store pending requests.
REQ-025 grant SHALL always be one-hot or zero; grant_idx SHALL always equal the encoded grant.

Reset
REQ-026 With rst_n=0 sampled on a rising edge, the block SHALL set state=IDLE, grant=0, grant_idx=all ones, busy=0, timeout=0, hold counter=0 and round-robin pointer=N_REQ-1.
REQ-027 Reset asserted mid-tenure SHALL drop the grant on that edge; the first grant after reset SHALL occur no earlier than the edge after rst_n returns to 1.

Configuration
REQ-028 Macro DW_ARB_BINCTL_RR_EN SHALL select the arbitration policy at compile time.
REQ-029 With DW_ARB_BINCTL_RR_EN defined, the winner SHALL be the highest requesting index strictly below the last winner, wrapping to N_REQ-1; the pointer SHALL update on each grant.
REQ-030 Without DW_ARB_BINCTL_RR_EN, the block SHALL use fixed highest-index priority and SHALL contain no pointer register.

Verification (N_REQ=8, MAX_HOLD=4)
REQ-031 Reset then req=8'h00 for 5 cycles -> grant=0, grant_idx=3'b111, busy=0 throughout.
REQ-032 req=8'h12 with enable=1 -> one cycle later grant=8'h10, grant_idx=4; drop req[4] -> next edge grant=8'h02, grant_idx=1 with no gap.
REQ-033 req=8'h80 held, lock=0 -> grant held for 4 cycles, then timeout=1 for one cycle, grant=0 for one cycle, then regrant to 7.
REQ-034 req=8'h81, lock=8'h80 -> grant to 7 held beyond 4 cycles with no timeout; clear lock -> forced release next edge, grant=8'h01.
REQ-035 RR build, req=8'hFF held with each owner dropping after 1 cycle -> grant_idx sequence 7,6,5,...,0,7; fixed build -> 7 repeatedly.
REQ-036 Grant to 3 active, enable=0, then rst_n=0 for one edge -> grant=0 on that edge; no grant while enable=0 after reset.
